nibble_serial_adder: RTL and testbench

- Multi-cycle wide-operand adder sequencer that sits directly upstream of the 4-bit structural adder slice.
- Latches two NIBBLES*4-bit operands on a start handshake and feeds one nibble pair per cycle, LSB first, into the external 4-bit adder.
- Captures each nibble sum and ripples the carry through an internal register.
- Presents the full-width sum and carry-out with a one-cycle done pulse.

---
 rtl/nibble_serial_adder.sv | 117 +++++++++++
 tb/tb_nibble_serial_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Wide-operand adder sequencer: feeds one nibble pair per cycle (LSB first) to an
// external 4-bit adder slice and ripples its carry. `define SIGNED_OVF_EN adds ovf.
module nibble_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
`ifdef SIGNED_OVF_EN
  output logic         ovf,
`endif
  output logic [3:0]   fa_a,
  output logic [3:0]   fa_b,
  output logic         fa_cin,
  input  logic [3:0]   fa_sum,
  input  logic         fa_cout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state;
  logic [NIBBLES-1:0][3:0] r_a;
  logic [NIBBLES-1:0][3:0] r_b;
  logic [NIBBLES-1:0][3:0] r_sum;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_carry;
  logic                    r_ready;
  logic                    r_done;
  logic                    r_cout;
  logic                    w_run;
  logic                    w_last;
`ifdef SIGNED_OVF_EN
  logic                    r_ovf;
`endif

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  // Adder slice sees zeros outside RUN so it never toggles on stale operands.
  assign fa_a   = w_run ? r_a[r_idx] : 4'h0;
  assign fa_b   = w_run ? r_b[r_idx] : 4'h0;
  assign fa_cin = w_run ? r_carry    : 1'b0;

  assign ready = r_ready;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;
`ifdef SIGNED_OVF_EN
  assign ovf   = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
`ifdef SIGNED_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_state <= S_RUN;
`ifdef SIGNED_OVF_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          r_sum[r_idx] <= fa_sum;
          r_carry      <= fa_cout;
          r_idx        <= r_idx + IDX_W'(1);
          if (w_last) begin
            // Final results are registered here so they are valid alongside done.
            r_idx   <= '0;
            r_cout  <= fa_cout;
            r_done  <= 1'b1;
            r_state <= S_DONE;
`ifdef SIGNED_OVF_EN
            r_ovf   <= (r_a[NIBBLES-1][3] == r_b[NIBBLES-1][3]) &&
                       (fa_sum[3] != r_a[NIBBLES-1][3]);
`endif
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder slice on
// the fa_* ports and an arithmetic reference model; ovf checks under SIGNED_OVF_EN.
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         ready, done, cout;
  logic [W-1:0] sum;
  logic [3:0]   fa_a, fa_b, fa_sum;
  logic         fa_cin, fa_cout;
`ifdef SIGNED_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // observations from the last do_op
  int           o_lat;
  logic         o_timeout;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic [N-1:0] o_trace;
  logic         o_rdy_run;
  logic         o_fa_done;
  logic         o_rdy_after;
  logic         o_done_after;
  logic         o_ovf;

  assign {fa_cout, fa_sum} = 5'(fa_a) + 5'(fa_b) + 5'(fa_cin);

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .done(done), .sum(sum), .cout(cout),
`ifdef SIGNED_OVF_EN
    .ovf(ovf),
`endif
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  function automatic logic [W:0] model_add(logic [W-1:0] x, logic [W-1:0] y, logic c);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  // carry entering nibble k = carry out of the low 4k bits
  function automatic logic model_carry_in(logic [W-1:0] x, logic [W-1:0] y, logic c, int k);
    longint unsigned m = (64'd1 << (4 * k)) - 64'd1;
    longint unsigned t = (64'(x) & m) + (64'(y) & m) + 64'(c);
    return t[4 * k];
  endfunction

  function automatic logic model_ovf(logic [W-1:0] x, logic [W-1:0] y, logic c);
    logic [W:0] r = model_add(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Issue one request; with hold=1 start stays high (operands scrambled) during RUN.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input bit hold);
    int k = 0;
    while (!ready && k < 20) begin @(posedge clk); #1; k++; end
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    if (hold) a = 16'hFFFF;
    else begin
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
    end
    cin = 1'($urandom);
    o_lat = 0; o_trace = '0; o_timeout = 1'b1; o_rdy_run = 1'b0;
    repeat (20) begin
      if (done) begin o_timeout = 1'b0; break; end
      if (o_lat < N) o_trace[o_lat] = fa_cin;
      o_rdy_run = o_rdy_run | ready;
      @(posedge clk); #1;
      o_lat++;
    end
    o_sum = sum; o_cout = cout;
    o_fa_done = |{fa_a, fa_b, fa_cin};
`ifdef SIGNED_OVF_EN
    o_ovf = ovf;
`else
    o_ovf = 1'b0;
`endif
    start = 1'b0;
    @(posedge clk); #1;
    o_rdy_after  = ready;
    o_done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1;
    #12;
    n_tests++;
    if ({ready, done, sum, cout, fa_a, fa_b, fa_cin} !== {1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b done=%b sum=%h cout=%b fa_a=%h fa_b=%h fa_cin=%b, required 1 0 0000 0 0 0 0",
               ready, done, sum, cout, fa_a, fa_b, fa_cin);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h0000};
    logic [W-1:0] vb [3] = '{16'h0FCD, 16'h0001, 16'h0000};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      logic [W:0]   r = model_add(va[i], vb[i], vc[i]);
      logic [N-1:0] tr;
      for (int k = 0; k < N; k++) tr[k] = model_carry_in(va[i], vb[i], vc[i], k);
      do_op(va[i], vb[i], vc[i], 1'b0);
      n_tests++;
      if (o_timeout || o_lat != N) begin
        n_fail++; $display("FAIL latency[%0d]: edges=%0d timeout=%b, required %0d", i, o_lat, o_timeout, N);
      end
      n_tests++;
      if ({o_cout, o_sum} !== r) begin
        n_fail++; $display("FAIL sum[%0d]: cout=%b sum=%h, required cout=%b sum=%h", i, o_cout, o_sum, r[W], r[W-1:0]);
      end
      n_tests++;
      if (o_trace !== tr) begin
        n_fail++; $display("FAIL carry_ripple[%0d]: fa_cin trace=%b, required %b", i, o_trace, tr);
      end
      n_tests++;
      if ({o_rdy_run, o_fa_done, o_rdy_after, o_done_after} !== 4'b0010) begin
        n_fail++; $display("FAIL handshake[%0d]: ready_in_run=%b fa_in_done=%b ready_after=%b done_after=%b, required 0 0 1 0",
                           i, o_rdy_run, o_fa_done, o_rdy_after, o_done_after);
      end
      // result must hold while idle, and the slice must stay quiet
      a = W'($urandom); b = W'($urandom);
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({cout, sum, fa_a, fa_b, fa_cin} !== {r, 4'h0, 4'h0, 1'b0}) begin
        n_fail++; $display("FAIL hold[%0d]: cout=%b sum=%h fa=%h/%h/%b, required cout=%b sum=%h fa=0",
                           i, cout, sum, fa_a, fa_b, fa_cin, r[W], r[W-1:0]);
      end
    end
  endtask

  task automatic test_start_during_run;
    int extra = 0;
    do_op(16'h1111, 16'h2222, 1'b0, 1'b1);
    n_tests++;
    if (o_timeout || o_lat != N || o_sum !== 16'h3333 || o_cout !== 1'b0 || o_rdy_run !== 1'b0) begin
      n_fail++; $display("FAIL start_during_run: edges=%0d sum=%h cout=%b ready_in_run=%b, required %0d 3333 0 0",
                         o_lat, o_sum, o_cout, o_rdy_run, N);
    end
    repeat (6) begin @(posedge clk); #1; if (done) extra++; end
    n_tests++;
    if (extra != 0 || o_done_after !== 1'b0) begin
      n_fail++; $display("FAIL single_done: extra done pulses=%0d, required 0", extra + int'(o_done_after));
    end
    do_op(16'h0102, 16'h0304, 1'b1, 1'b0);
    n_tests++;
    if (o_timeout || {o_cout, o_sum} !== 17'h00407) begin
      n_fail++; $display("FAIL second_request: sum=%h, required 0407", o_sum);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen = 0;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({ready, done, sum, cout, fa_a, fa_b, fa_cin} !== {1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_run: ready=%b done=%b sum=%h cout=%b fa_a=%h, required 1 0 0000 0 0",
                         ready, done, sum, cout, fa_a);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (done) seen++; end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_no_done: done pulses=%0d, required 0", seen);
    end
    do_op(16'h0005, 16'h0003, 1'b0, 1'b0);
    n_tests++;
    if (o_timeout || {o_cout, o_sum} !== 17'h00008) begin
      n_fail++; $display("FAIL after_reset: cout=%b sum=%h, required 0 0008", o_cout, o_sum);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x = W'($urandom);
      logic [W-1:0] y = (i % 4 == 0) ? ~x : W'($urandom);
      logic         c = 1'($urandom);
      logic [W:0]   r = model_add(x, y, c);
      logic [N-1:0] tr;
      for (int k = 0; k < N; k++) tr[k] = model_carry_in(x, y, c, k);
      do_op(x, y, c, 1'b0);
      n_tests++;
      if (o_timeout || o_lat != N || {o_cout, o_sum} !== r || o_trace !== tr || o_rdy_after !== 1'b1) begin
        n_fail++; $display("FAIL random[%0d]: %h+%h+%b -> cout=%b sum=%h trace=%b edges=%0d, required cout=%b sum=%h trace=%b edges=%0d",
                           i, x, y, c, o_cout, o_sum, o_trace, o_lat, r[W], r[W-1:0], tr, N);
      end
`ifdef SIGNED_OVF_EN
      n_tests++;
      if (o_ovf !== model_ovf(x, y, c)) begin
        n_fail++; $display("FAIL random_ovf[%0d]: ovf=%b, required %b", i, o_ovf, model_ovf(x, y, c));
      end
`endif
    end
  endtask

`ifdef SIGNED_OVF_EN
  task automatic test_ovf;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    n_tests++;
    if ({o_ovf, o_cout, o_sum} !== {1'b1, 1'b0, 16'h8000}) begin
      n_fail++; $display("FAIL ovf_pos: ovf=%b cout=%b sum=%h, required 1 0 8000", o_ovf, o_cout, o_sum);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_hold: ovf=%b, required 1", ovf);
    end
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    n_tests++;
    if ({o_ovf, o_cout, o_sum} !== {1'b0, 1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL ovf_neg: ovf=%b cout=%b sum=%h, required 0 1 0000", o_ovf, o_cout, o_sum);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_start_during_run;
    test_reset_mid_run;
`ifdef SIGNED_OVF_EN
    test_ovf;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
